// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO read-side controller.
package fifo_pkg;

  // Read-side sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Output buffer depth; two entries cover the one-cycle memory read latency
  localparam int OBUF_DEPTH = 2;
  localparam int OCCW       = $clog2(OBUF_DEPTH + 1);

endpackage

// File: rtl/fifo_obuf.sv
// Two-entry output buffer: push at the tail, pop from the head, synchronous clear.
module fifo_obuf
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [DSIZE-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic             o_valid,
  output logic [DSIZE-1:0] o_head,
  output logic [OCCW-1:0]  o_occ
);

  logic [DSIZE-1:0] r_slot0;
  logic [DSIZE-1:0] r_slot1;
  logic [OCCW-1:0]  r_occ;
  logic             w_pop;
  logic             w_push;

  // Guard against popping an empty buffer or pushing into a full one
  always_comb begin
    w_pop  = i_pop & (r_occ != '0);
    w_push = i_push & ((r_occ != OCCW'(OBUF_DEPTH)) | w_pop);
  end

  // Slot 0 is always the head; slot 1 shifts forward on a pop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_occ   <= '0;
    end else if (i_clear) begin
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == '0) r_slot0 <= i_push_data;
          else             r_slot1 <= i_push_data;
          r_occ <= r_occ + OCCW'(1);
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_occ   <= r_occ - OCCW'(1);
        end
        2'b11: begin
          if (r_occ == OCCW'(1)) begin
            r_slot0 <= i_push_data;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_occ != '0);
  assign o_head  = r_slot0;
  assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side sequencer for the async FIFO: pop issue, output buffering, flush/drain, stats.
//
// state  | meaning
// IDLE   | no new pops; buffered entries still drain downstream
// STREAM | pops issued whenever the output buffer is guaranteed room
// FLUSH  | buffer cleared, FIFO popped until empty, returned data discarded
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             flush,
  input  logic             rempty,
  input  logic             arempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic             low_water,
  output logic             flush_busy,
  output logic             flush_done,
  output logic [CNTW-1:0]  pop_cnt,
  output logic [CNTW-1:0]  drop_cnt
);

  state_e           r_state;
  state_e           w_next;
  logic             r_inflight;
  logic             r_low_water;
  logic             r_flush_done;
  logic [CNTW-1:0]  r_pop_cnt;
  logic [CNTW-1:0]  r_drop_cnt;

  logic [OCCW-1:0]  w_occ;
  logic             w_hs;
  logic             w_flush_go;
  logic [2:0]       w_fill;
  logic             w_rinc;
  logic             w_drain_done;
  logic             w_push;
  logic [CNTW-1:0]  w_drop_inc;

  fifo_obuf #(.DSIZE(DSIZE)) u_obuf (
    .i_clk       (rclk),
    .i_rst       (rrst),
    .i_push      (w_push),
    .i_push_data (mem_rdata),
    .i_pop       (w_hs),
    .i_clear     (w_flush_go),
    .o_valid     (m_valid),
    .o_head      (m_data),
    .o_occ       (w_occ)
  );

  // Pop decision, drain detection and next-state selection
  always_comb begin
    w_hs       = m_valid & m_ready;
    w_flush_go = flush & (r_state != FLUSH);
    // Entries that will occupy the buffer after this cycle's handshake
    w_fill     = 3'(w_occ) + 3'(r_inflight) - 3'(w_hs);

    w_rinc = 1'b0;
    case (r_state)
      STREAM:  w_rinc = en & ~rempty & (w_fill < 3'd2);
      FLUSH:   w_rinc = ~rempty;
      default: w_rinc = 1'b0;
    endcase

    w_drain_done = (r_state == FLUSH) & rempty & ~r_inflight & ~w_rinc;
    // Returning data is only kept outside FLUSH and not on the flush-entry cycle
    w_push       = r_inflight & (r_state != FLUSH) & ~w_flush_go;

    if (w_flush_go)            w_drop_inc = CNTW'(w_fill);
    else if (r_state == FLUSH) w_drop_inc = CNTW'(r_inflight);
    else                       w_drop_inc = '0;

    w_next = r_state;
    if (w_flush_go) begin
      w_next = FLUSH;
    end else begin
      case (r_state)
        IDLE:    if (en) w_next = STREAM;
        STREAM:  if (!en && !r_inflight) w_next = IDLE;
        FLUSH:   if (w_drain_done) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // State, inflight tracking, status flags and statistics
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state      <= IDLE;
      r_inflight   <= 1'b0;
      r_low_water  <= 1'b0;
      r_flush_done <= 1'b0;
      r_pop_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      r_inflight   <= w_rinc;
      r_low_water  <= (r_state == STREAM) & arempty;
      r_flush_done <= w_drain_done;
      r_pop_cnt    <= r_pop_cnt + CNTW'(w_hs);
      r_drop_cnt   <= r_drop_cnt + w_drop_inc;
    end
  end

  assign rinc       = w_rinc;
  assign low_water  = r_low_water;
  assign flush_busy = (r_state == FLUSH);
  assign flush_done = r_flush_done;
  assign pop_cnt    = r_pop_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: queue-based FIFO model on the read side plus an in-order scoreboard.
module tb_fifo_rd_ctrl;

  localparam int DSIZE = 8;
  localparam int CNTW  = 4;

  logic             rclk = 1'b0;
  logic             rrst, en, flush, rempty, arempty, rinc;
  logic [DSIZE-1:0] mem_rdata, m_data;
  logic             m_valid, m_ready, low_water, flush_busy, flush_done;
  logic [CNTW-1:0]  pop_cnt, drop_cnt;

  fifo_rd_ctrl #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
    .rclk(rclk), .rrst(rrst), .en(en), .flush(flush), .rempty(rempty), .arempty(arempty),
    .rinc(rinc), .mem_rdata(mem_rdata), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .low_water(low_water), .flush_busy(flush_busy), .flush_done(flush_done),
    .pop_cnt(pop_cnt), .drop_cnt(drop_cnt)
  );

  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] q[$];   // entries stored in the FIFO memory
  logic [DSIZE-1:0] sb[$];  // entries expected downstream, in order
  int tests = 0, fails = 0;
  int written = 0, deliv = 0, written_snap = 0;
  int cyc = 0, n_rinc = 0, first_rinc = -1, last_rinc = -1, first_dlv = -1, last_dlv = -1;
  bit done_seen = 0, chk_lw = 0, lw_prev_valid = 0;
  logic lw_prev = 1'b0;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_flags();
    rempty  = (q.size() == 0);
    arempty = (q.size() <= 1);
  endtask

  task automatic wr(input logic [DSIZE-1:0] d);
    q.push_back(d);
    sb.push_back(d);
    written++;
    upd_flags();
  endtask

  // One clock: observe at the falling edge, apply FIFO-side effects just after the rising edge
  task automatic step();
    logic l_rinc;
    logic [DSIZE-1:0] e;
    @(negedge rclk);
    cyc++;
    if (!rrst) begin
      chk("rinc_while_empty", 32'(rinc & rempty), 0);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("unexpected_delivery", 1, 0);
        else begin
          e = sb.pop_front();
          chk("m_data_order", 32'(m_data), 32'(e));
        end
        deliv++;
        if (first_dlv < 0) first_dlv = cyc;
        last_dlv = cyc;
      end
      if (chk_lw && lw_prev_valid) chk("low_water_track", 32'(low_water), 32'(lw_prev));
      if (flush && !flush_busy) begin
        sb.delete();
        written_snap = written;
      end
      if (flush_done) begin
        done_seen = 1;
        chk("drop_cnt_at_done", 32'(drop_cnt), (written_snap - deliv) & 15);
        chk("busy_low_at_done", 32'(flush_busy), 0);
      end
    end
    lw_prev = arempty;
    lw_prev_valid = 1;
    l_rinc = rinc;
    if (rinc) begin
      n_rinc++;
      if (first_rinc < 0) first_rinc = cyc;
      last_rinc = cyc;
    end
    @(posedge rclk);
    #1;
    if (l_rinc && q.size() > 0) mem_rdata = q.pop_front();
    else                        mem_rdata = DSIZE'($urandom);
    upd_flags();
  endtask

  task automatic wait_done(input string tag);
    done_seen = 0;
    for (int i = 0; i < 40 && !done_seen; i++) step();
    chk(tag, 32'(done_seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst = 1; en = 1; flush = 0; m_ready = 1; rempty = 1; arempty = 1; mem_rdata = '0;
    repeat (3) step();
    chk("rst_rinc", 32'(rinc), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_pop_cnt", 32'(pop_cnt), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_flush_busy", 32'(flush_busy), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    chk("rst_low_water", 32'(low_water), 0);
    rrst = 0;
    step();

    // Four entries at full rate
    n_rinc = 0; first_rinc = -1; first_dlv = -1;
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    repeat (10) step();
    chk("burst_rinc_count", n_rinc, 4);
    chk("burst_rinc_consecutive", last_rinc - first_rinc, 3);
    chk("burst_deliv_consecutive", last_dlv - first_dlv, 3);
    chk("burst_pop_cnt", 32'(pop_cnt), 4);

    // Backpressure: only two pops may issue, then full rate on release
    m_ready = 0; n_rinc = 0;
    for (int i = 0; i < 6; i++) wr(8'hB0 + 8'(i));
    repeat (8) step();
    chk("bp_rinc_count", n_rinc, 2);
    chk("bp_m_valid", 32'(m_valid), 1);
    chk("bp_rinc_held", 32'(rinc), 0);
    chk("bp_stored", q.size(), 4);
    m_ready = 1; first_dlv = -1; base = deliv;
    for (int i = 0; i < 20 && (deliv - base) < 6; i++) step();
    chk("bp_deliv_count", deliv - base, 6);
    chk("bp_deliv_span", last_dlv - first_dlv, 5);
    chk("bp_pop_cnt", 32'(pop_cnt), 10);

    // Flush with entries buffered, in flight and stored; a second flush mid-drain is ignored
    m_ready = 0;
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    step(); step();
    flush = 1; step(); flush = 0;
    chk("fl_m_valid_cleared", 32'(m_valid), 0);
    chk("fl_busy", 32'(flush_busy), 1);
    flush = 1; step(); flush = 0;
    wait_done("fl_done_timeout");
    chk("fl_drop_cnt", 32'(drop_cnt), 6);
    chk("fl_fifo_empty", 32'(rempty), 1);
    chk("fl_stored", q.size(), 0);
    step();
    chk("fl_done_pulse", 32'(flush_done), 0);

    // Flush coinciding with a handshake on 0x55
    m_ready = 0;
    wr(8'h55); wr(8'h66); wr(8'h77);
    for (int i = 0; i < 10 && !m_valid; i++) step();
    chk("hs_head", 32'(m_data), 32'h55);
    base = deliv;
    m_ready = 1; flush = 1; step(); flush = 0;
    chk("hs_one_delivery", deliv - base, 1);
    wait_done("hs_done_timeout");
    chk("hs_pop_cnt", 32'(pop_cnt), 11);
    chk("hs_drop_cnt", 32'(drop_cnt), 8);

    // en dropped with one entry in flight
    m_ready = 1; n_rinc = 0;
    for (int i = 0; i < 5; i++) wr(8'(($urandom)));
    for (int i = 0; i < 10 && n_rinc == 0; i++) step();
    chk("en_first_pop", n_rinc, 1);
    en = 0; n_rinc = 0;
    repeat (6) step();
    chk("en_no_pops", n_rinc, 0);
    chk("en_inflight_delivered", sb.size(), q.size());
    chk("en_m_valid", 32'(m_valid), 0);
    en = 1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    chk("en_resume_drained", sb.size(), 0);
    chk("en_pop_cnt_wrap", 32'(pop_cnt), 0);

    // low_water only in STREAM
    repeat (2) step();
    chk("lw_stream", 32'(low_water), 1);
    en = 0; repeat (3) step();
    chk("lw_idle", 32'(low_water), 0);
    en = 1; repeat (3) step();
    chk("lw_stream_again", 32'(low_water), 1);

    // Reset mid-operation
    m_ready = 0;
    for (int i = 0; i < 4; i++) wr(8'(($urandom)));
    step(); step();
    rrst = 1; step();
    chk("mrst_rinc", 32'(rinc), 0);
    chk("mrst_m_valid", 32'(m_valid), 0);
    chk("mrst_pop_cnt", 32'(pop_cnt), 0);
    chk("mrst_drop_cnt", 32'(drop_cnt), 0);
    q.delete(); sb.delete(); written = 0; deliv = 0; written_snap = 0;
    upd_flags();
    rrst = 0;

    // Random traffic until 17 deliveries, low_water tracked each cycle
    step(); step();
    chk_lw = 1;
    for (int i = 0; i < 400 && deliv < 17; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && written < 30) wr(8'($urandom));
      step();
    end
    chk_lw = 0;
    chk("wrap_deliv_count", deliv, 17);
    chk("wrap_pop_cnt", 32'(pop_cnt), 1);

    // Random traffic with en changes and flushes
    for (int i = 0; i < 300; i++) begin
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if (!flush_busy && !flush && $urandom_range(0, 29) == 0) flush = 1;
      else begin
        flush = 0;
        if (!flush_busy && $urandom_range(0, 2) == 0) wr(8'($urandom));
      end
      step();
    end
    flush = 0; en = 1; m_ready = 1;
    for (int i = 0; i < 100 && (sb.size() > 0 || q.size() > 0 || flush_busy); i++) step();
    chk("rand_drained", sb.size(), 0);
    chk("rand_pop_cnt", 32'(pop_cnt), deliv & 15);
    m_ready = 0;
    for (int i = 0; i < 3; i++) wr(8'($urandom));
    step(); step();
    flush = 1; step(); flush = 0;
    wait_done("final_done_timeout");
    chk("final_drop_cnt", 32'(drop_cnt), (written - deliv) & 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
